// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RISC-V pipe: forwarding selects, load-use stall,
// branch flush and memory-wait freeze. Define HAZARD_PERF_CNT_EN to add saturating event counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt,
  output logic [15:0] MemWaitCnt
`endif
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_MEMWAIT, S_HALT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [REG_W-1:0] r_rs1e;
  logic [REG_W-1:0] r_rs2e;
  logic [REG_W-1:0] r_rde;
  logic [REG_W-1:0] r_rdm;
  logic [REG_W-1:0] r_rdw;

  logic w_reset;
  logic w_mem_miss;
  logic w_lw_stall;
  logic w_frozen;

  // M beats W; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input logic [REG_W-1:0] rdm,
                                         input logic [REG_W-1:0] rdw,
                                         input logic             rwm,
                                         input logic             rww);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (rwm && (rs == rdm))      sel = 2'b10;
      else if (rww && (rs == rdw)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign w_reset    = rst | (r_state == S_RESET);
  assign w_mem_miss = MemReqM & ~MemReadyM;
  assign w_lw_stall = ResultSrcE0 & (r_rde != '0) & ((r_rde == Rs1D) | (r_rde == Rs2D));
  // Freeze covers the first not-ready cycle in RUN plus every MEMWAIT/HALT cycle.
  assign w_frozen   = ~w_reset & ((r_state != S_RUN) | w_mem_miss);

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    MemErr    = 1'b0;
    if (w_reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(r_rs1e, r_rdm, r_rdw, RegWriteM, RegWriteW);
      ForwardBE = fwd_sel(r_rs2e, r_rdm, r_rdw, RegWriteM, RegWriteW);
      if (w_frozen) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
        MemErr = (r_state == S_HALT);
      end else begin
        FlushD = PCSrcE;
        FlushE = PCSrcE | w_lw_stall;
        StallF = w_lw_stall & ~PCSrcE;
        StallD = w_lw_stall & ~PCSrcE;
      end
    end
  end

  // Sequencer state, wait counter and the private Rs/Rd field pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RESET;
      r_wait_cnt <= '0;
      r_rs1e     <= '0;
      r_rs2e     <= '0;
      r_rde      <= '0;
      r_rdm      <= '0;
      r_rdw      <= '0;
    end else begin
      case (r_state)
        S_RESET: r_state <= S_RUN;
        S_RUN: begin
          if (w_mem_miss) begin
            r_state    <= S_MEMWAIT;
            r_wait_cnt <= CNT_W'(1);
          end
        end
        S_MEMWAIT: begin
          if (MemReadyM) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt >= TIMEOUT_C) begin
            r_state <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_HALT;
      endcase

      if (r_state == S_RESET) begin
        r_rs1e <= '0;
        r_rs2e <= '0;
        r_rde  <= '0;
        r_rdm  <= '0;
        r_rdw  <= '0;
      end else begin
        if (!StallE) begin
          r_rs1e <= FlushE ? '0 : Rs1D;
          r_rs2e <= FlushE ? '0 : Rs2D;
          r_rde  <= FlushE ? '0 : RdD;
        end
        if (!StallM) r_rdm <= r_rde;
        r_rdw <= FlushW ? '0 : r_rdm;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned PERF_W = 16;

  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;
  logic [PERF_W-1:0] r_memwait_cnt;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + PERF_W'(1) : v;
  endfunction

  // Event counters saturate rather than wrap so a long run never reads as quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_memwait_cnt <= '0;
    end else begin
      r_stall_cnt   <= sat_inc(r_stall_cnt, (r_state == S_RUN) & w_lw_stall);
      r_flush_cnt   <= sat_inc(r_flush_cnt, (r_state == S_RUN) & PCSrcE);
      r_memwait_cnt <= sat_inc(r_memwait_cnt, r_state == S_MEMWAIT);
    end
  end

  assign StallCnt   = r_stall_cnt;
  assign FlushCnt   = r_flush_cnt;
  assign MemWaitCnt = r_memwait_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal pins plus a randomized run
// compared every cycle against a slot-level pipeline model.
module tb_hazard_ctrl;

  localparam int unsigned TO = 4;
  localparam int MD_RESET = 0, MD_RUN = 1, MD_WAIT = 2, MD_HALT = 3;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } slot_t;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] StallCnt, FlushCnt, MemWaitCnt;
  int m_sc = 0, m_fc = 0, m_mc = 0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: mode, consecutive not-ready count, and instruction slots E(0), M(1), W(2).
  int    mode = MD_RESET;
  int    nr = 0;
  slot_t pipe [3] = '{default: '0};

  logic [11:0] pin_mask = '0;
  logic [11:0] pin_val = '0;
  string       pin_name = "";

  logic [11:0] dut_v, exp_v;
  logic        m_rst, m_frz, m_lw, m_fd, m_fe, m_fw, m_sf, m_se, m_me;
  logic [1:0]  m_fa, m_fb;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt), .MemWaitCnt(MemWaitCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dut_v = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, MemErr};

  function automatic logic [1:0] fsel(input logic [4:0] r, input slot_t m, input slot_t w,
                                      input logic rwm, input logic rww);
    if (r == 5'd0) return 2'b00;
    if (rwm && (m.rd == r)) return 2'b10;
    if (rww && (w.rd == r)) return 2'b01;
    return 2'b00;
  endfunction

  // Single compare process: model outputs, literal pins, then advance the model.
  always @(negedge clk) begin
    cyc++;
    m_rst = rst || (mode == MD_RESET);
    m_lw  = ResultSrcE0 && (pipe[0].rd != 5'd0) && ((pipe[0].rd == Rs1D) || (pipe[0].rd == Rs2D));
    m_frz = !m_rst && ((mode != MD_RUN) || (MemReqM && !MemReadyM));
    {m_fd, m_fe, m_fw, m_sf, m_se, m_me} = '0;
    m_fa = 2'b00;
    m_fb = 2'b00;
    if (m_rst) begin
      {m_fd, m_fe, m_fw} = 3'b111;
    end else begin
      m_fa = fsel(pipe[0].rs1, pipe[1], pipe[2], RegWriteM, RegWriteW);
      m_fb = fsel(pipe[0].rs2, pipe[1], pipe[2], RegWriteM, RegWriteW);
      if (m_frz) begin
        m_sf = 1'b1; m_se = 1'b1; m_fw = 1'b1;
        m_me = (mode == MD_HALT);
      end else begin
        m_fd = PCSrcE;
        m_fe = PCSrcE || m_lw;
        m_sf = m_lw && !PCSrcE;
      end
    end
    exp_v = {m_sf, m_sf, m_se, m_se, m_fd, m_fe, m_fw, m_fa, m_fb, m_me};

    checks++;
    if (dut_v !== exp_v) begin
      failures++;
      $display("FAIL model cyc=%0d got %b want %b", cyc, dut_v, exp_v);
    end
    if (pin_mask != 12'h000) begin
      checks++;
      if ((dut_v & pin_mask) !== (pin_val & pin_mask)) begin
        failures++;
        $display("FAIL pin_%s got %b want %b mask %b", pin_name, dut_v, pin_val, pin_mask);
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({StallCnt, FlushCnt, MemWaitCnt} !== {16'(m_sc), 16'(m_fc), 16'(m_mc)}) begin
      failures++;
      $display("FAIL perf cyc=%0d got %0d/%0d/%0d want %0d/%0d/%0d", cyc,
               StallCnt, FlushCnt, MemWaitCnt, m_sc, m_fc, m_mc);
    end
    if (rst) begin
      m_sc = 0; m_fc = 0; m_mc = 0;
    end else begin
      if (mode == MD_RUN && m_lw && m_sc < 65535) m_sc++;
      if (mode == MD_RUN && PCSrcE && m_fc < 65535) m_fc++;
      if (mode == MD_WAIT && m_mc < 65535) m_mc++;
    end
`endif

    if (rst) begin
      mode = MD_RESET;
      nr = 0;
    end else begin
      case (mode)
        MD_RESET: mode = MD_RUN;
        MD_RUN: if (MemReqM && !MemReadyM) begin mode = MD_WAIT; nr = 1; end
        MD_WAIT: begin
          if (MemReadyM) begin
            mode = MD_RUN; nr = 0;
          end else begin
            nr++;
            if (nr > int'(TO)) mode = MD_HALT;
          end
        end
        default: ;
      endcase
    end
    if (m_rst) begin
      pipe = '{default: '0};
    end else if (m_frz) begin
      pipe[2] = '0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (PCSrcE || m_lw) ? '0 : slot_t'({Rs1D, Rs2D, RdD});
    end
  end

  task automatic drive(input logic r, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic ld, input logic pc, input logic rwm, input logic rww,
                       input logic mq, input logic mr,
                       input string nm, input logic [11:0] msk, input logic [11:0] val);
    @(posedge clk);
    #1;
    rst = r; Rs1D = a; Rs2D = b; RdD = d;
    ResultSrcE0 = ld; PCSrcE = pc; RegWriteM = rwm; RegWriteW = rww;
    MemReqM = mq; MemReadyM = mr;
    pin_name = nm; pin_mask = msk; pin_val = val;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "", 12'h000, 12'h000);
  endtask

  initial begin
    int slow;
    rst = 1'b1; Rs1D = '0; Rs2D = '0; RdD = '0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b1;

    // Reset: flushes only, then one RESET cycle, then clean RUN.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rst", 12'hFFF, 12'h0E0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset_state", 12'hFFF, 12'h0E0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "run_idle", 12'hFFF, 12'h000);

    // Forward from M only.
    drive(0, 0, 0, 5, 0, 0, 0, 0, 0, 1, "", 12'h000, 12'h000);
    drive(0, 5, 0, 0, 0, 0, 0, 0, 0, 1, "", 12'h000, 12'h000);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "fwd_m", 12'h018, 12'h010);
    idle(3);
    // M and W both match (M wins), then W only, then x0.
    drive(0, 0, 0, 5, 0, 0, 0, 0, 0, 1, "", 12'h000, 12'h000);
    drive(0, 0, 0, 5, 0, 0, 0, 0, 0, 1, "", 12'h000, 12'h000);
    drive(0, 5, 0, 0, 0, 0, 0, 0, 0, 1, "", 12'h000, 12'h000);
    drive(0, 5, 0, 0, 0, 0, 1, 1, 0, 1, "fwd_m_over_w", 12'h018, 12'h010);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, "fwd_w", 12'h018, 12'h008);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "fwd_x0", 12'h018, 12'h000);
    idle(3);

    // Load-use on Rs2, then W forwarding once the load retires.
    drive(0, 0, 0, 7, 0, 0, 0, 0, 0, 1, "", 12'h000, 12'h000);
    drive(0, 0, 7, 0, 1, 0, 0, 0, 0, 1, "lw_stall", 12'hC40, 12'hC40);
    drive(0, 0, 7, 0, 0, 0, 0, 0, 0, 1, "lw_release", 12'hC40, 12'h000);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "lw_fwd_w", 12'h006, 12'h002);
    idle(3);

    // Branch flush for exactly one cycle; flushed slot must not cause a load-use stall.
    drive(0, 0, 0, 9, 0, 0, 0, 0, 0, 1, "", 12'h000, 12'h000);
    drive(0, 0, 0, 4, 0, 1, 0, 0, 0, 1, "br_flush", 12'h0C0, 12'h0C0);
    drive(0, 4, 9, 0, 1, 0, 0, 0, 0, 1, "br_after", 12'h8C0, 12'h000);
    idle(3);

    // Memory wait: 3 not-ready cycles then ready, branch ignored while frozen.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "mw_1", 12'hFE1, 12'hF20);
    drive(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, "mw_2", 12'hFE1, 12'hF20);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "mw_3", 12'hFE1, 12'hF20);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "mw_ready", 12'hFE1, 12'hF20);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "mw_done", 12'hFE1, 12'h000);
    idle(3);

    // Timeout: RUN miss + 4 MEMWAIT cycles, then sticky HALT until reset.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "to_run", 12'hFE1, 12'hF20);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "to_wait", 12'hFE1, 12'hF20);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "to_last", 12'hFE1, 12'hF20);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "halt", 12'hFE1, 12'hF21);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, "halt_sticky", 12'hFE1, 12'hF21);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "halt_rst", 12'hFE1, 12'h0E0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "halt_reset_state", 12'hFE1, 12'h0E0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "halt_run", 12'hFFF, 12'h000);

    // Randomized traffic with occasional slow-memory stretches and rare resets.
    slow = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) slow = ($urandom_range(0, 2) == 0) ? 1 : 0;
      drive(($urandom_range(0, 99) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 3) == 0),
            (slow != 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0),
            "", 12'h000, 12'h000);
    end
    idle(1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
